// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared VRAM arbiter types, address map and region helper
package vram_pkg;

    localparam int VRAM_AW = 13;

    localparam logic [VRAM_AW-1:0] PIX_BASE  = 13'h0000;
    localparam logic [VRAM_AW-1:0] ATTR_BASE = 13'h1800;
    localparam logic [VRAM_AW-1:0] ATTR_END  = 13'h1AFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        ACK    = 2'd3
    } vram_state_t;

    function automatic logic is_attr(input logic [VRAM_AW-1:0] a);
        return (a >= ATTR_BASE) && (a <= ATTR_END);
    endfunction

endpackage

// File: rtl/vram_wbuf.sv
// rtl/vram_wbuf.sv - one-entry posted write buffer with address hit compare
module vram_wbuf
    import vram_pkg::*;
#(
    parameter int AW = VRAM_AW
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          i_load,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_data,
    input  logic          i_drain,
    output logic          o_valid,
    output logic [AW-1:0] o_addr,
    output logic [7:0]    o_data,
    output logic          o_hit
);
    logic          r_valid;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_data;

    // Load only happens while empty and drain only while full, so they never collide.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= 8'h00;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_data  <= i_data;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_hit   = r_valid && (r_addr == i_addr);

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - VGA/CPU arbiter for the single-port 8 KB video RAM
// VRAM_POSTED_WRITE_EN adds a one-entry posted write buffer for CPU writes.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW       = VRAM_AW,
    parameter int MAX_WAIT = 7
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          vga_rd,
    input  logic [AW-1:0] vga_a,
    output logic [7:0]    vga_i,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_ready,
    output logic [AW-1:0] mem_a,
    output logic [7:0]    mem_d,
    output logic          mem_we,
    input  logic [7:0]    mem_q,
    output logic          starve
);
    vram_state_t   r_state;
    vram_state_t   w_next;
    logic [2:0]    r_wait_cnt;
    logic [7:0]    r_rdata;
    logic          r_starve;
    logic          w_pending;
    logic          w_do_access;
    logic          w_fast_ack;
    logic          w_hit_rd;
    logic          w_can_access;
    logic          w_drain;
    logic [AW-1:0] w_drain_a;
    logic [7:0]    w_drain_d;

    assign w_pending   = cpu_req && (r_state == IDLE || r_state == WAIT);
    // An ACCESS cycle that collides with a VGA slot simply repeats next cycle.
    assign w_do_access = (r_state == ACCESS) && !vga_rd;

`ifdef VRAM_POSTED_WRITE_EN
    logic w_buf_valid;
    logic w_buf_hit;
    logic w_post;

    vram_wbuf #(.AW(AW)) u_wbuf (
        .clock   (clock),
        .reset_n (reset_n),
        .i_load  (w_post),
        .i_addr  (cpu_addr),
        .i_data  (cpu_wdata),
        .i_drain (w_drain),
        .o_valid (w_buf_valid),
        .o_addr  (w_drain_a),
        .o_data  (w_drain_d),
        .o_hit   (w_buf_hit)
    );

    assign w_post       = w_pending && cpu_we && !w_buf_valid;
    assign w_hit_rd     = w_pending && !cpu_we && w_buf_hit;
    assign w_fast_ack   = w_post || w_hit_rd;
    assign w_can_access = !vga_rd && !w_buf_valid;
    assign w_drain      = w_buf_valid && !vga_rd;
`else
    assign w_hit_rd     = 1'b0;
    assign w_fast_ack   = 1'b0;
    assign w_can_access = !vga_rd;
    assign w_drain      = 1'b0;
    assign w_drain_a    = '0;
    assign w_drain_d    = 8'h00;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, WAIT: begin
                if (!cpu_req)
                    w_next = IDLE;
                else if (w_fast_ack)
                    w_next = ACK;
                else if (w_can_access)
                    w_next = ACCESS;
                else
                    w_next = WAIT;
            end
            ACCESS:  if (!vga_rd) w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_wait_cnt <= 3'd0;
            r_rdata    <= 8'h00;
            r_starve   <= 1'b0;
        end else begin
            r_state <= w_next;
            // A blocked WAIT cycle seen with the counter already at MAX_WAIT is the one that overruns.
            if (r_state == WAIT && w_next == WAIT) begin
                if (r_wait_cnt != 3'd7)
                    r_wait_cnt <= r_wait_cnt + 3'd1;
                if (int'(r_wait_cnt) >= MAX_WAIT)
                    r_starve <= 1'b1;
            end else begin
                r_wait_cnt <= 3'd0;
            end
            if (w_do_access && !cpu_we)
                r_rdata <= mem_q;
            else if (w_hit_rd)
                r_rdata <= w_drain_d;
        end
    end

    assign mem_a     = vga_rd ? vga_a : (w_drain ? w_drain_a : cpu_addr);
    assign mem_d     = w_drain ? w_drain_d : cpu_wdata;
    assign mem_we    = reset_n && !vga_rd && ((w_do_access && cpu_we) || w_drain);
    assign vga_i     = mem_q;
    assign cpu_rdata = r_rdata;
    assign cpu_ack   = (r_state == ACK);
    assign cpu_ready = ~(cpu_req & ~cpu_ack);
    assign starve    = r_starve;

endmodule
